rvfi_cover_stats: RTL and testbench

- Parametrised retirement-statistics block for cover runs. It generalises the per-channel cover counters to a configurable counter width with saturation.
- Aggregates retirements across all NRET channels per cycle and tracks burst and stall runs with a small state machine.
- Sits beside the core wrapper on the RVFI bus. Its registered outputs are the targets for the cover statements.

---
 rtl/rvfi_cover_stats.sv | 170 +++++++++++++++++
 tb/tb_rvfi_cover_stats.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_cover_stats.sv
// Retirement statistics for RVFI cover runs: saturating counters, burst/gap tracking, freeze on check.
// Optional rollback accounting is compiled in with RISCV_FORMAL_COVER_ROLLBACK_EN.
module rvfi_cover_stats #(
  parameter int unsigned NRET  = 1,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned GAP_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             check,
  input  logic [NRET-1:0]  rvfi_valid,
  input  logic [NRET-1:0]  rvfi_trap,
  input  logic [NRET-1:0]  rvfi_intr,
`ifdef RISCV_FORMAL_COVER_ROLLBACK_EN
  input  logic             rvfi_rollback_valid,
  output logic [CNT_W-1:0] cnt_rollback,
  output logic [CNT_W-1:0] arb_cnt_insns,
  output logic [CNT_W-1:0] arb_cnt_trap,
  output logic [CNT_W-1:0] arb_cnt_intr,
  output logic [CNT_W-1:0] arb_cnt_norm,
`endif
  output logic [CNT_W-1:0] cnt_insns,
  output logic [CNT_W-1:0] cnt_trap,
  output logic [CNT_W-1:0] cnt_intr,
  output logic [CNT_W-1:0] cnt_norm,
  output logic [CNT_W-1:0] cnt_multi,
  output logic [GAP_W-1:0] max_burst,
  output logic [GAP_W-1:0] max_gap,
  output logic [GAP_W-1:0] cur_run,
  output logic [1:0]       state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] STALL = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int unsigned SW  = $clog2(NRET + 1);
  localparam int unsigned CW1 = CNT_W + 1;

  logic [SW-1:0]    sum_v, sum_t, sum_i, sum_n;
  logic             any, multi;
  logic [1:0]       nxt_state;
  logic [GAP_W-1:0] nxt_run;

  // Add at CNT_W+1 bits so overflow is visible and clamps to all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [SW-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + CW1'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a);
    return (&a) ? a : a + CNT_W'(1);
  endfunction

  function automatic logic [GAP_W-1:0] run_inc(input logic [GAP_W-1:0] r);
    return (&r) ? r : r + GAP_W'(1);
  endfunction

  always_comb begin
    sum_v = '0;
    sum_t = '0;
    sum_i = '0;
    sum_n = '0;
    for (int unsigned k = 0; k < NRET; k++) begin
      sum_v = sum_v + SW'(rvfi_valid[k]);
      sum_t = sum_t + SW'(rvfi_valid[k] & rvfi_trap[k]);
      sum_i = sum_i + SW'(rvfi_valid[k] & rvfi_intr[k]);
      sum_n = sum_n + SW'(rvfi_valid[k] & ~rvfi_trap[k] & ~rvfi_intr[k]);
    end
    any   = (sum_v != '0);
    multi = (sum_v >= SW'(2));
  end

  always_comb begin
    nxt_state = state;
    nxt_run   = cur_run;
    case (state)
      IDLE: begin
        if (any) begin
          nxt_state = RUN;
          nxt_run   = GAP_W'(1);
        end
      end
      RUN: begin
        if (any) begin
          nxt_run = run_inc(cur_run);
        end else begin
          nxt_state = STALL;
          nxt_run   = GAP_W'(1);
        end
      end
      STALL: begin
        if (!any) begin
          nxt_run = run_inc(cur_run);
        end else begin
          nxt_state = RUN;
          nxt_run   = GAP_W'(1);
        end
      end
      default: ;
    endcase
`ifdef RISCV_FORMAL_COVER_ROLLBACK_EN
    if (rvfi_rollback_valid && (state == RUN || state == STALL)) begin
      nxt_state = STALL;
      nxt_run   = GAP_W'(1);
    end
`endif
    // check wins over every run transition; the run length is frozen as it stands.
    if (check) begin
      nxt_state = DONE;
      nxt_run   = cur_run;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_insns <= '0;
      cnt_trap  <= '0;
      cnt_intr  <= '0;
      cnt_norm  <= '0;
      cnt_multi <= '0;
      max_burst <= '0;
      max_gap   <= '0;
      cur_run   <= '0;
      state     <= IDLE;
    end else if (state != DONE) begin
      cnt_insns <= sat_add(cnt_insns, sum_v);
      cnt_trap  <= sat_add(cnt_trap, sum_t);
      cnt_intr  <= sat_add(cnt_intr, sum_i);
      cnt_norm  <= sat_add(cnt_norm, sum_n);
      if (multi) begin
        cnt_multi <= sat_inc(cnt_multi);
      end
      if (nxt_state == RUN && nxt_run > max_burst) begin
        max_burst <= nxt_run;
      end
      if (nxt_state == STALL && nxt_run > max_gap) begin
        max_gap <= nxt_run;
      end
      cur_run <= nxt_run;
      state   <= nxt_state;
    end
  end

`ifdef RISCV_FORMAL_COVER_ROLLBACK_EN
  // arb_* gate on the registered rollback count, so the first rollback cycle is excluded.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_rollback  <= '0;
      arb_cnt_insns <= '0;
      arb_cnt_trap  <= '0;
      arb_cnt_intr  <= '0;
      arb_cnt_norm  <= '0;
    end else if (state != DONE) begin
      if (rvfi_rollback_valid) begin
        cnt_rollback <= sat_inc(cnt_rollback);
      end
      if (cnt_rollback != '0) begin
        arb_cnt_insns <= sat_add(arb_cnt_insns, sum_v);
        arb_cnt_trap  <= sat_add(arb_cnt_trap, sum_t);
        arb_cnt_intr  <= sat_add(arb_cnt_intr, sum_i);
        arb_cnt_norm  <= sat_add(arb_cnt_norm, sum_n);
      end
    end
  end
`endif

endmodule

// File: tb/tb_rvfi_cover_stats.sv
// Directed bench for rvfi_cover_stats: vector table on a 2-channel instance plus
// saturation sequences on a narrow 4-channel instance.
module tb_rvfi_cover_stats;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Instance A: NRET=2, default widths
  logic        a_reset = 1'b1, a_check = 1'b0;
  logic [1:0]  a_valid = '0, a_trap = '0, a_intr = '0;
  logic [15:0] a_insns, a_trp, a_itr, a_nrm, a_mul;
  logic [7:0]  a_mb, a_mg, a_cr;
  logic [1:0]  a_st;

  // Instance S: NRET=4, CNT_W=4, GAP_W=3
  logic        s_reset = 1'b1, s_check = 1'b0;
  logic [3:0]  s_valid = '0, s_trap = '0, s_intr = '0;
  logic [3:0]  s_insns, s_trp, s_itr, s_nrm, s_mul;
  logic [2:0]  s_mb, s_mg, s_cr;
  logic [1:0]  s_st;

`ifdef RISCV_FORMAL_COVER_ROLLBACK_EN
  logic        a_rb = 1'b0;
  logic [15:0] a_cnt_rb, a_arb_insns, a_arb_trap, a_arb_intr, a_arb_norm;
  logic [3:0]  s_cnt_rb, s_arb_insns, s_arb_trap, s_arb_intr, s_arb_norm;
`endif

  rvfi_cover_stats #(.NRET(2), .CNT_W(16), .GAP_W(8)) dut_a (
    .clock(clock), .reset(a_reset), .check(a_check),
    .rvfi_valid(a_valid), .rvfi_trap(a_trap), .rvfi_intr(a_intr),
`ifdef RISCV_FORMAL_COVER_ROLLBACK_EN
    .rvfi_rollback_valid(a_rb), .cnt_rollback(a_cnt_rb),
    .arb_cnt_insns(a_arb_insns), .arb_cnt_trap(a_arb_trap),
    .arb_cnt_intr(a_arb_intr), .arb_cnt_norm(a_arb_norm),
`endif
    .cnt_insns(a_insns), .cnt_trap(a_trp), .cnt_intr(a_itr), .cnt_norm(a_nrm),
    .cnt_multi(a_mul), .max_burst(a_mb), .max_gap(a_mg), .cur_run(a_cr), .state(a_st)
  );

  rvfi_cover_stats #(.NRET(4), .CNT_W(4), .GAP_W(3)) dut_s (
    .clock(clock), .reset(s_reset), .check(s_check),
    .rvfi_valid(s_valid), .rvfi_trap(s_trap), .rvfi_intr(s_intr),
`ifdef RISCV_FORMAL_COVER_ROLLBACK_EN
    .rvfi_rollback_valid(1'b0), .cnt_rollback(s_cnt_rb),
    .arb_cnt_insns(s_arb_insns), .arb_cnt_trap(s_arb_trap),
    .arb_cnt_intr(s_arb_intr), .arb_cnt_norm(s_arb_norm),
`endif
    .cnt_insns(s_insns), .cnt_trap(s_trp), .cnt_intr(s_itr), .cnt_norm(s_nrm),
    .cnt_multi(s_mul), .max_burst(s_mb), .max_gap(s_mg), .cur_run(s_cr), .state(s_st)
  );

  typedef struct {
    logic       r, c;
    logic [1:0] v, t, i;
    int         ins, trp, itr, nrm, mul, mb, mg, cr, st;
  } vec_t;

  function automatic vec_t mk(logic r, logic c, logic [1:0] v, logic [1:0] t, logic [1:0] i,
                              int ins, int trp, int itr, int nrm, int mul,
                              int mb, int mg, int cr, int st);
    vec_t x;
    x.r = r; x.c = c; x.v = v; x.t = t; x.i = i;
    x.ins = ins; x.trp = trp; x.itr = itr; x.nrm = nrm; x.mul = mul;
    x.mb = mb; x.mg = mg; x.cr = cr; x.st = st;
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step_a(input logic r, input logic c, input logic [1:0] v,
                        input logic [1:0] t, input logic [1:0] i);
    @(negedge clock);
    a_reset = r; a_check = c; a_valid = v; a_trap = t; a_intr = i;
    @(posedge clock);
    #1;
  endtask

  task automatic step_s(input logic r, input logic [3:0] v, input logic [3:0] t);
    @(negedge clock);
    s_reset = r; s_check = 1'b0; s_valid = v; s_trap = t; s_intr = '0;
    @(posedge clock);
    #1;
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  vec_t tbl[26];

  initial begin
    //              r  c  v      t      i      ins trp itr nrm mul mb mg cr st
    tbl[0]  = mk(1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 2'b11, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 2'b11, 2'b00, 2'b00, 2, 0, 0, 2, 1, 1, 0, 1, 1);
    tbl[4]  = mk(1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 2'b01, 2'b00, 2'b00, 1, 0, 0, 1, 0, 1, 0, 1, 1);
    tbl[6]  = mk(0, 0, 2'b01, 2'b00, 2'b00, 2, 0, 0, 2, 0, 2, 0, 2, 1);
    tbl[7]  = mk(0, 0, 2'b01, 2'b00, 2'b00, 3, 0, 0, 3, 0, 3, 0, 3, 1);
    tbl[8]  = mk(0, 0, 2'b00, 2'b00, 2'b00, 3, 0, 0, 3, 0, 3, 1, 1, 2);
    tbl[9]  = mk(0, 0, 2'b00, 2'b00, 2'b00, 3, 0, 0, 3, 0, 3, 2, 2, 2);
    tbl[10] = mk(0, 0, 2'b01, 2'b00, 2'b00, 4, 0, 0, 4, 0, 3, 2, 1, 1);
    tbl[11] = mk(1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 2'b01, 2'b01, 2'b00, 1, 1, 0, 0, 0, 1, 0, 1, 1);
    tbl[13] = mk(0, 0, 2'b01, 2'b00, 2'b01, 2, 1, 1, 0, 0, 2, 0, 2, 1);
    tbl[14] = mk(0, 0, 2'b01, 2'b01, 2'b01, 3, 2, 2, 0, 0, 3, 0, 3, 1);
    tbl[15] = mk(0, 0, 2'b00, 2'b11, 2'b11, 3, 2, 2, 0, 0, 3, 1, 1, 2);
    tbl[16] = mk(0, 0, 2'b11, 2'b10, 2'b00, 5, 3, 2, 1, 1, 3, 1, 1, 1);
    tbl[17] = mk(1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[18] = mk(0, 0, 2'b01, 2'b00, 2'b00, 1, 0, 0, 1, 0, 1, 0, 1, 1);
    tbl[19] = mk(0, 1, 2'b01, 2'b00, 2'b00, 2, 0, 0, 2, 0, 1, 0, 1, 3);
    tbl[20] = mk(0, 0, 2'b11, 2'b11, 2'b00, 2, 0, 0, 2, 0, 1, 0, 1, 3);
    tbl[21] = mk(0, 0, 2'b00, 2'b00, 2'b00, 2, 0, 0, 2, 0, 1, 0, 1, 3);
    tbl[22] = mk(1, 1, 2'b11, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[23] = mk(0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[24] = mk(0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    tbl[25] = mk(1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 26; n++) begin
      step_a(tbl[n].r, tbl[n].c, tbl[n].v, tbl[n].t, tbl[n].i);
      chk($sformatf("v%0d cnt_insns", n), int'(a_insns), tbl[n].ins);
      chk($sformatf("v%0d cnt_trap", n),  int'(a_trp),   tbl[n].trp);
      chk($sformatf("v%0d cnt_intr", n),  int'(a_itr),   tbl[n].itr);
      chk($sformatf("v%0d cnt_norm", n),  int'(a_nrm),   tbl[n].nrm);
      chk($sformatf("v%0d cnt_multi", n), int'(a_mul),   tbl[n].mul);
      chk($sformatf("v%0d max_burst", n), int'(a_mb),    tbl[n].mb);
      chk($sformatf("v%0d max_gap", n),   int'(a_mg),    tbl[n].mg);
      chk($sformatf("v%0d cur_run", n),   int'(a_cr),    tbl[n].cr);
      chk($sformatf("v%0d state", n),     int'(a_st),    tbl[n].st);
    end

    // Counter saturation at 15 with four channels retiring every cycle
    step_s(1'b1, 4'h0, 4'h0);
    chk("sat reset insns", int'(s_insns), 0);
    for (int k = 1; k <= 5; k++) begin
      step_s(1'b0, 4'hF, 4'h0);
      chk($sformatf("sat%0d cnt_insns", k), int'(s_insns), imin(4 * k, 15));
      chk($sformatf("sat%0d cnt_multi", k), int'(s_mul), k);
      chk($sformatf("sat%0d cur_run", k),   int'(s_cr), k);
    end
    // Gap run saturation at 7
    for (int k = 1; k <= 9; k++) begin
      step_s(1'b0, 4'h0, 4'h0);
      chk($sformatf("gap%0d cur_run", k), int'(s_cr), imin(k, 7));
      chk($sformatf("gap%0d max_gap", k), int'(s_mg), imin(k, 7));
      chk($sformatf("gap%0d state", k),   int'(s_st), 2);
    end
    // Burst run, cnt_multi and cnt_trap saturation
    for (int k = 1; k <= 12; k++) begin
      step_s(1'b0, 4'h3, 4'h3);
      chk($sformatf("brs%0d cur_run", k),   int'(s_cr), imin(k, 7));
      chk($sformatf("brs%0d max_burst", k), int'(s_mb), imax(5, imin(k, 7)));
      chk($sformatf("brs%0d cnt_multi", k), int'(s_mul), imin(5 + k, 15));
      chk($sformatf("brs%0d cnt_trap", k),  int'(s_trp), imin(2 * k, 15));
      chk($sformatf("brs%0d cnt_insns", k), int'(s_insns), 15);
    end

`ifdef RISCV_FORMAL_COVER_ROLLBACK_EN
    step_a(1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
    step_a(1'b0, 1'b0, 2'b01, 2'b00, 2'b00);
    step_a(1'b0, 1'b0, 2'b01, 2'b00, 2'b00);
    a_rb = 1'b1;
    step_a(1'b0, 1'b0, 2'b01, 2'b00, 2'b00);
    a_rb = 1'b0;
    chk("rb cycle state", int'(a_st), 2);
    chk("rb cycle cur_run", int'(a_cr), 1);
    chk("rb cycle cnt_rollback", int'(a_cnt_rb), 1);
    chk("rb cycle arb_cnt_insns", int'(a_arb_insns), 0);
    chk("rb cycle cnt_insns", int'(a_insns), 3);
    for (int k = 0; k < 3; k++) step_a(1'b0, 1'b0, 2'b01, 2'b00, 2'b00);
    chk("rb end cnt_rollback", int'(a_cnt_rb), 1);
    chk("rb end cnt_insns", int'(a_insns), 6);
    chk("rb end arb_cnt_insns", int'(a_arb_insns), 3);
    chk("rb end arb_cnt_norm", int'(a_arb_norm), 3);
    chk("rb end arb_cnt_trap", int'(a_arb_trap), 0);
    chk("rb end cur_run", int'(a_cr), 3);
    chk("rb end max_burst", int'(a_mb), 3);
    chk("rb end max_gap", int'(a_mg), 1);
    step_a(1'b1, 1'b0, 2'b00, 2'b00, 2'b00);
    chk("rb reset cnt_rollback", int'(a_cnt_rb), 0);
    chk("rb reset arb_cnt_insns", int'(a_arb_insns), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
